// File: rtl/pc_unit.sv
// Fetch-stage program counter with halt FSM, alignment trap and optional RAS.
// Define PC_RAS_EN to build the return-address stack.
module pc_unit #(
    parameter int unsigned          XLEN        = 32,
    parameter logic [XLEN-1:0]      RESET_VEC   = 32'h0000_0000,
    parameter logic [XLEN-1:0]      TRAP_VEC    = 32'h0000_0080,
    parameter int unsigned          INSTR_BYTES = 4,
    parameter int unsigned          RAS_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            halt,
    input  logic            resume,
    input  logic            trap,
    input  logic            branch,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            call,
    input  logic            ret,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next,
    output logic            misalign,
    output logic            halted,
    output logic            ras_empty
);

    typedef enum logic {RUN, HALTED} state_t;

    localparam logic [XLEN-1:0] STEP  = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] AMASK = XLEN'(INSTR_BYTES - 1);

    state_t          state, state_n;
    logic [XLEN-1:0] pc_n, seq_pc, ras_top;
    logic            mis_n, ras_hit, push, pop;

    assign seq_pc = pc + STEP;

    always_comb begin
        pc_n    = pc;
        state_n = state;
        mis_n   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        unique case (state)
            RUN: begin
                if (trap) begin
                    pc_n = TRAP_VEC;
                end else if (halt && !resume) begin
                    state_n = HALTED;
                end else if (stall) begin
                    pc_n = pc;
                end else if (ret) begin
                    // an empty stack degrades ret to a plain step
                    if (!ras_hit) begin
                        pc_n = seq_pc;
                    end else if ((ras_top & AMASK) != '0) begin
                        pc_n  = TRAP_VEC;
                        mis_n = 1'b1;
                    end else begin
                        pc_n = ras_top;
                        pop  = 1'b1;
                    end
                end else if (jump) begin
                    if ((jump_target & AMASK) != '0) begin
                        pc_n  = TRAP_VEC;
                        mis_n = 1'b1;
                    end else begin
                        pc_n = jump_target;
                        push = call;
                    end
                end else if (branch) begin
                    if ((branch_target & AMASK) != '0) begin
                        pc_n  = TRAP_VEC;
                        mis_n = 1'b1;
                    end else begin
                        pc_n = branch_target;
                    end
                end else begin
                    pc_n = seq_pc;
                end
            end
            HALTED: begin
                if (trap) begin
                    state_n = RUN;
                    pc_n    = TRAP_VEC;
                end else if (resume) begin
                    state_n = RUN;
                end
            end
        endcase
    end

    assign pc_next = rst ? RESET_VEC : pc_n;
    assign halted  = (state == HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_VEC;
            state    <= RUN;
            misalign <= 1'b0;
        end else begin
            pc       <= pc_n;
            state    <= state_n;
            misalign <= mis_n;
        end
    end

`ifdef PC_RAS_EN
    localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   top, top_up, top_dn;
    logic [CW-1:0]   count;
    logic            empty_q;

    assign top_up    = (top == LAST) ? '0 : top + 1'b1;
    assign top_dn    = (top == '0) ? LAST : top - 1'b1;
    assign ras_top   = ras_mem[top];
    assign ras_hit   = (count != '0);
    assign ras_empty = empty_q;

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            ras_mem[top_up] <= seq_pc;
        end
    end

    // full pushes wrap onto the oldest slot; count saturates
    always_ff @(posedge clk) begin
        if (rst) begin
            top     <= LAST;
            count   <= '0;
            empty_q <= 1'b1;
        end else if (push) begin
            top     <= top_up;
            empty_q <= 1'b0;
            if (count != FULL) begin
                count <= count + 1'b1;
            end
        end else if (pop) begin
            top     <= top_dn;
            count   <= count - 1'b1;
            empty_q <= (count == CW'(1));
        end
    end
`else
    logic unused_ras;

    assign ras_top    = seq_pc;
    assign ras_hit    = 1'b0;
    assign ras_empty  = 1'b1;
    assign unused_ras = ^{push, pop, call, ras_top};
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: queue-based reference model checked every
// cycle, plus literal expectations at the interesting points.
module tb_pc_unit;

    localparam logic [31:0] TRAP = 32'h0000_0080;
`ifdef PC_RAS_EN
    localparam bit HAS_RAS = 1'b1;
`else
    localparam bit HAS_RAS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, halt = 1'b0, resume = 1'b0, trap = 1'b0;
    logic        branch = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0;
    logic [31:0] branch_target = '0, jump_target = '0;
    logic [31:0] pc, pc_next;
    logic        misalign, halted, ras_empty;

    int total = 0;
    int bad   = 0;

    pc_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .halt(halt),
        .resume(resume), .trap(trap), .branch(branch),
        .branch_target(branch_target), .jump(jump),
        .jump_target(jump_target), .call(call), .ret(ret),
        .pc(pc), .pc_next(pc_next), .misalign(misalign),
        .halted(halted), .ras_empty(ras_empty)
    );

    always #5 clk = ~clk;

    // reference state
    logic [31:0] m_pc;
    bit          m_halted, m_mis, m_ready = 1'b0;
    logic [31:0] ras_q[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit aligned(input logic [31:0] a);
        return a[1:0] == 2'b00;
    endfunction

    // op: 0 none, 1 push, 2 pop
    task automatic model_eval(output logic [31:0] npc, output bit nh,
                              output bit nm, output int op);
        npc = m_pc; nh = m_halted; nm = 1'b0; op = 0;
        if (m_halted) begin
            if (trap) begin
                npc = TRAP; nh = 1'b0;
            end else if (resume) begin
                nh = 1'b0;
            end
        end else if (trap) begin
            npc = TRAP;
        end else if (halt && !resume) begin
            nh = 1'b1;
        end else if (stall) begin
            npc = m_pc;
        end else if (ret) begin
            if (HAS_RAS && ras_q.size() > 0) begin
                if (!aligned(ras_q[$])) begin
                    npc = TRAP; nm = 1'b1;
                end else begin
                    npc = ras_q[$]; op = 2;
                end
            end else begin
                npc = m_pc + 32'd4;
            end
        end else if (jump) begin
            if (!aligned(jump_target)) begin
                npc = TRAP; nm = 1'b1;
            end else begin
                npc = jump_target;
                if (HAS_RAS && call) op = 1;
            end
        end else if (branch) begin
            if (!aligned(branch_target)) begin
                npc = TRAP; nm = 1'b1;
            end else begin
                npc = branch_target;
            end
        end else begin
            npc = m_pc + 32'd4;
        end
    endtask

    always @(posedge clk) begin
        logic [31:0] npc;
        bit nh, nm;
        int op;
        if (rst) begin
            m_pc = 32'h0; m_halted = 1'b0; m_mis = 1'b0;
            ras_q.delete();
            m_ready = 1'b1;
        end else if (m_ready) begin
            model_eval(npc, nh, nm, op);
            if (op == 1) begin
                ras_q.push_back(m_pc + 32'd4);
                if (ras_q.size() > 4) void'(ras_q.pop_front());
            end else if (op == 2) begin
                void'(ras_q.pop_back());
            end
            m_pc = npc; m_halted = nh; m_mis = nm;
        end
    end

    always @(negedge clk) begin
        logic [31:0] npc;
        bit nh, nm;
        int op;
        if (m_ready) begin
            model_eval(npc, nh, nm, op);
            chk("pc", pc, m_pc);
            chk("pc_next", pc_next, rst ? 32'h0 : npc);
            chk("misalign", 32'(misalign), 32'(m_mis));
            chk("halted", 32'(halted), 32'(m_halted));
            chk("ras_empty", 32'(ras_empty), 32'(ras_q.size() == 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        stall = 1'b0; halt = 1'b0; resume = 1'b0; trap = 1'b0;
        branch = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_pc", pc, 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_misalign", 32'(misalign), 32'h0);
        chk("rst_ras_empty", 32'(ras_empty), 32'h1);

        repeat (3) tick();
        chk("seq_0c", pc, 32'h0C);
        tick();
        chk("seq_10", pc, 32'h10);

        branch = 1'b1; branch_target = 32'h200;
        jump = 1'b1; jump_target = 32'h300;
        tick();
        chk("jump_over_branch", pc, 32'h300);
        stall = 1'b1; branch = 1'b1; branch_target = 32'h200;
        tick();
        chk("stall_hold", pc, 32'h300);

        branch = 1'b1; branch_target = 32'h102;
        tick();
        chk("misal_pc", pc, 32'h80);
        chk("misal_flag", 32'(misalign), 32'h1);
        tick();
        chk("misal_clear", 32'(misalign), 32'h0);
        chk("after_trap_seq", pc, 32'h84);

        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        tick();
        chk("top_addr", pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap", pc, 32'h0);

        jump = 1'b1; jump_target = 32'h40;
        tick();
        halt = 1'b1;
        tick();
        chk("halt_flag", 32'(halted), 32'h1);
        for (int i = 0; i < 5; i++) begin
            branch = 1'b1; branch_target = 32'h200;
            tick();
            chk("halt_hold", pc, 32'h40);
        end
        trap = 1'b1;
        tick();
        chk("trap_pc", pc, 32'h80);
        chk("trap_unhalt", 32'(halted), 32'h0);
        stall = 1'b1; trap = 1'b1;
        tick();
        chk("trap_over_stall", pc, 32'h80);
        tick();
        halt = 1'b1;
        tick();
        resume = 1'b1;
        tick();
        chk("resume_pc", pc, 32'h84);
        chk("resume_flag", 32'(halted), 32'h0);

        branch = 1'b1; branch_target = 32'h106;
        tick();
        stall = 1'b1;
        tick();
        chk("stall_mis_clear", 32'(misalign), 32'h0);
        chk("stall_mis_pc", pc, 32'h80);

        jump = 1'b1; jump_target = 32'h10;
        tick();
        for (int i = 1; i <= 5; i++) begin
            jump = 1'b1; call = 1'b1; jump_target = 32'(16 * (i + 1));
            tick();
        end
        chk("calls_pc", pc, 32'h60);
`ifdef PC_RAS_EN
        chk("ras_full", 32'(ras_empty), 32'h0);
        ret = 1'b1; tick(); chk("ret1", pc, 32'h54);
        ret = 1'b1; tick(); chk("ret2", pc, 32'h44);
        ret = 1'b1; tick(); chk("ret3", pc, 32'h34);
        ret = 1'b1; tick(); chk("ret4", pc, 32'h24);
        chk("ras_drained", 32'(ras_empty), 32'h1);
        ret = 1'b1; tick(); chk("ret_empty", pc, 32'h28);
        chk("ras_still_empty", 32'(ras_empty), 32'h1);
        jump = 1'b1; call = 1'b1; jump_target = 32'h103;
        tick();
        chk("call_misal_pc", pc, 32'h80);
        chk("call_misal_nopush", 32'(ras_empty), 32'h1);
        jump = 1'b1; call = 1'b1; jump_target = 32'h200;
        tick();
        ret = 1'b1; jump = 1'b1; call = 1'b1; jump_target = 32'h300;
        tick();
        chk("ret_over_call", pc, 32'h84);
        chk("ret_over_call_nopush", 32'(ras_empty), 32'h1);
`else
        ret = 1'b1;
        tick();
        chk("ret_seq", pc, 32'h64);
        chk("ras_tied", 32'(ras_empty), 32'h1);
`endif
        tick();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
